jtag_tap_driver: RTL and testbench

- Host-side JTAG initiator that drives the on-chip TAP controller's TCK/TMS/TDI pins and samples TDO.
- Accepts one command per transaction: optional IR scan (e.g. EXTEST, SAMPLE, PRELOAD, LOAD_PROGRAM, BYPASS), then DR scan of up to DR_MAX bits.
- Returns the captured DR bits.
- Used by the program-load path and by testbenches to push data through the TAP.

---
 rtl/jtag_tap_driver.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_jtag_tap_driver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_driver.sv
// Host-side JTAG initiator: runs an optional IR scan and then a DR scan per command, returning captured TDO bits.
// Defining JTAG_IR_CHECK_EN turns on the IR capture-pattern check that drives ir_err.
module jtag_tap_driver #(
    parameter int IR_WIDTH = 4,
    parameter int DR_MAX   = 32,
    parameter int CLK_DIV  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic                cmd_skip_ir,
    input  logic [DR_MAX-1:0]   cmd_dr,
    input  logic [5:0]          cmd_dr_len,
    output logic                rsp_valid,
    output logic [DR_MAX-1:0]   rsp_data,
    output logic                ir_err,
    output logic                tck,
    output logic                tms,
    output logic                tdi,
    input  logic                tdo
);
    localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       IR_LAST    = 6'(IR_WIDTH - 1);
    localparam logic [5:0]       DR_MAX_LEN = 6'(DR_MAX);

    typedef enum logic [3:0] {
        RESET_SEQ, IDLE, IR_PRE, IR_SHIFT, IR_POST, DR_PRE, DR_SHIFT, DR_POST, DONE
    } state_t;

    state_t              state_r, state_nx_s;
    logic [2:0]          step_r, step_nx_s;
    logic [5:0]          cnt_r, cnt_nx_s;
    logic [DIV_W-1:0]    div_r;
    logic                phase_r;
    logic                running_s, rise_s, fall_s, accept_s;
    logic [5:0]          len_clamp_s, len_r;
    logic [IR_WIDTH-1:0] ir_r;
    logic [DR_MAX-1:0]   dr_r;
    logic                tck_r, tms_r, tdi_r, cmd_ready_r, rsp_valid_r;
    logic [DR_MAX-1:0]   rsp_data_r;
    logic                tms_nx_s, tdi_nx_s;
    logic [5:0]          ir_idx_s, dr_idx_s, cur_dr_idx_s;

    function automatic logic pick_ir(input logic [IR_WIDTH-1:0] v, input logic [5:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < IR_WIDTH; i++) begin
            if (idx == 6'(i)) b = v[i];
        end
        return b;
    endfunction

    function automatic logic pick_dr(input logic [DR_MAX-1:0] v, input logic [5:0] idx);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DR_MAX; i++) begin
            if (idx == 6'(i)) b = v[i];
        end
        return b;
    endfunction

    // TCK half-period strobes: rise ends a low half, fall ends a high half and advances the sequence
    always_comb begin
        running_s   = (state_r != IDLE) && (state_r != DONE);
        rise_s      = running_s && (div_r == DIV_LAST) && !phase_r;
        fall_s      = running_s && (div_r == DIV_LAST) && phase_r;
        accept_s    = cmd_valid && cmd_ready_r;
        len_clamp_s = (cmd_dr_len > DR_MAX_LEN) ? DR_MAX_LEN : cmd_dr_len;
    end

    // Half-period divider; held in the low-half start position whenever no sequence runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (!running_s) begin
            div_r   <= '0;
            phase_r <= 1'b0;
        end else if (div_r == DIV_LAST) begin
            div_r   <= '0;
            phase_r <= !phase_r;
        end else begin
            div_r   <= div_r + DIV_W'(1);
        end
    end

    // Next-state logic: each state/step/count position describes one TCK period
    always_comb begin
        state_nx_s = state_r;
        step_nx_s  = step_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            RESET_SEQ: begin
                if (fall_s) begin
                    if (step_r == 3'd5) begin
                        state_nx_s = IDLE;
                        step_nx_s  = 3'd0;
                    end else begin
                        step_nx_s  = step_r + 3'd1;
                    end
                end else begin
                    state_nx_s = RESET_SEQ;
                end
            end
            IDLE, DONE: begin
                if (accept_s) begin
                    step_nx_s = 3'd0;
                    if (!cmd_skip_ir) begin
                        state_nx_s = IR_PRE;
                    end else if (len_clamp_s != 6'd0) begin
                        state_nx_s = DR_PRE;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            IR_PRE: begin
                if (fall_s && (step_r == 3'd3)) begin
                    state_nx_s = IR_SHIFT;
                    step_nx_s  = 3'd0;
                    cnt_nx_s   = IR_LAST;
                end else if (fall_s) begin
                    step_nx_s  = step_r + 3'd1;
                end else begin
                    state_nx_s = IR_PRE;
                end
            end
            IR_SHIFT: begin
                if (fall_s && (cnt_r == 6'd0)) begin
                    state_nx_s = IR_POST;
                end else if (fall_s) begin
                    cnt_nx_s   = cnt_r - 6'd1;
                end else begin
                    state_nx_s = IR_SHIFT;
                end
            end
            IR_POST: begin
                if (fall_s && (step_r == 3'd1)) begin
                    step_nx_s  = 3'd0;
                    state_nx_s = (len_r != 6'd0) ? DR_PRE : DONE;
                end else if (fall_s) begin
                    step_nx_s  = step_r + 3'd1;
                end else begin
                    state_nx_s = IR_POST;
                end
            end
            DR_PRE: begin
                if (fall_s && (step_r == 3'd2)) begin
                    state_nx_s = DR_SHIFT;
                    step_nx_s  = 3'd0;
                    cnt_nx_s   = len_r - 6'd1;
                end else if (fall_s) begin
                    step_nx_s  = step_r + 3'd1;
                end else begin
                    state_nx_s = DR_PRE;
                end
            end
            DR_SHIFT: begin
                if (fall_s && (cnt_r == 6'd0)) begin
                    state_nx_s = DR_POST;
                end else if (fall_s) begin
                    cnt_nx_s   = cnt_r - 6'd1;
                end else begin
                    state_nx_s = DR_SHIFT;
                end
            end
            DR_POST: begin
                if (fall_s && (step_r == 3'd1)) begin
                    state_nx_s = DONE;
                    step_nx_s  = 3'd0;
                end else if (fall_s) begin
                    step_nx_s  = step_r + 3'd1;
                end else begin
                    state_nx_s = DR_POST;
                end
            end
            default: begin
                state_nx_s = RESET_SEQ;
                step_nx_s  = 3'd0;
                cnt_nx_s   = 6'd0;
            end
        endcase
    end

    // TMS/TDI for the TCK period that the next state describes; registered so they change on the falling edge
    always_comb begin
        tms_nx_s     = 1'b0;
        tdi_nx_s     = 1'b0;
        ir_idx_s     = IR_LAST - cnt_nx_s;
        dr_idx_s     = len_r - 6'd1 - cnt_nx_s;
        cur_dr_idx_s = len_r - 6'd1 - cnt_r;
        case (state_nx_s)
            RESET_SEQ: tms_nx_s = (step_nx_s != 3'd5);
            IR_PRE:    tms_nx_s = (step_nx_s < 3'd2);
            IR_SHIFT: begin
                tms_nx_s = (cnt_nx_s == 6'd0);
                tdi_nx_s = pick_ir(ir_r, ir_idx_s);
            end
            IR_POST:   tms_nx_s = (step_nx_s == 3'd0);
            DR_PRE:    tms_nx_s = (step_nx_s == 3'd0);
            DR_SHIFT: begin
                tms_nx_s = (cnt_nx_s == 6'd0);
                tdi_nx_s = pick_dr(dr_r, dr_idx_s);
            end
            DR_POST:   tms_nx_s = (step_nx_s == 3'd0);
            default:   tms_nx_s = 1'b0;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= RESET_SEQ;
            step_r  <= 3'd0;
            cnt_r   <= 6'd0;
        end else begin
            state_r <= state_nx_s;
            step_r  <= step_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Pin outputs, handshake, command latch and DR capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            cmd_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            len_r       <= 6'd0;
            ir_r        <= '0;
            dr_r        <= '0;
        end else begin
            tms_r       <= tms_nx_s;
            tdi_r       <= tdi_nx_s;
            cmd_ready_r <= (state_nx_s == IDLE) || (state_nx_s == DONE);
            rsp_valid_r <= (state_nx_s == DONE);
            if (rise_s) begin
                tck_r <= 1'b1;
            end else if (fall_s) begin
                tck_r <= 1'b0;
            end
            if (accept_s) begin
                ir_r  <= cmd_ir;
                dr_r  <= cmd_dr;
                len_r <= len_clamp_s;
            end
            // A zero-length response is known to be all zeros at acceptance
            if (accept_s && (len_clamp_s == 6'd0)) begin
                rsp_data_r <= '0;
            end else if ((state_r != DR_PRE) && (state_nx_s == DR_PRE)) begin
                rsp_data_r <= '0;
            end else if (rise_s && (state_r == DR_SHIFT)) begin
                for (int i = 0; i < DR_MAX; i++) begin
                    if (cur_dr_idx_s == 6'(i)) rsp_data_r[i] <= tdo;
                end
            end
        end
    end

`ifdef JTAG_IR_CHECK_EN
    logic [1:0] ir_cap_r;
    logic       ir_ran_r;
    logic       ir_err_r;
    logic [5:0] cur_ir_idx_s;

    // Index of the IR bit being shifted in the current TCK
    always_comb begin
        cur_ir_idx_s = IR_LAST - cnt_r;
    end

    // The first two IR capture bits must read 1 then 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_cap_r <= 2'b00;
            ir_ran_r <= 1'b0;
            ir_err_r <= 1'b0;
        end else if (accept_s) begin
            ir_cap_r <= 2'b00;
            ir_ran_r <= !cmd_skip_ir;
            ir_err_r <= 1'b0;
        end else begin
            if (rise_s && (state_r == IR_SHIFT) && (cur_ir_idx_s == 6'd0)) begin
                ir_cap_r[0] <= tdo;
            end else if (rise_s && (state_r == IR_SHIFT) && (cur_ir_idx_s == 6'd1)) begin
                ir_cap_r[1] <= tdo;
            end
            if ((state_nx_s == DONE) && (state_r != DONE) && ir_ran_r && (ir_cap_r != 2'b01)) begin
                ir_err_r <= 1'b1;
            end
        end
    end

    assign ir_err = ir_err_r;
`else
    assign ir_err = 1'b0;
`endif

    assign tck       = tck_r;
    assign tms       = tms_r;
    assign tdi       = tdi_r;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Scoreboard bench for jtag_tap_driver against a behavioural TAP with 1-bit loopback/bypass data registers.
module tb_jtag_tap_driver;
    localparam int IR_W = 4;
    localparam int DRM  = 32;
    localparam int CD   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_skip_ir = 1'b0;
    logic [3:0]  cmd_ir = 4'h0;
    logic [31:0] cmd_dr = 32'h0;
    logic [5:0]  cmd_dr_len = 6'd0;
    logic        cmd_ready, rsp_valid, ir_err, tck, tms, tdi;
    logic [31:0] rsp_data;
    logic        tdo_r = 1'b0;

    jtag_tap_driver #(.IR_WIDTH(IR_W), .DR_MAX(DRM), .CLK_DIV(CD)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_skip_ir(cmd_skip_ir), .cmd_dr(cmd_dr), .cmd_dr_len(cmd_dr_len),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ir_err(ir_err),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo_r)
    );

    always #5 clk = ~clk;

    // TAP model
    typedef enum logic [3:0] {
        TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
        SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR
    } tap_t;

    tap_t         tap_st = TLR;
    logic         dr_bit = 1'b0;
    logic [3:0]   ir_sh = 4'h0;
    logic [3:0]   ir_reg = 4'hF;
    logic [3:0]   ir_cap_pat = 4'b0001;
    logic [127:0] tms_hist = '0;
    int           tck_total = 0;
    int           dr_shifts = 0;

    function automatic tap_t next_tap(input tap_t s, input logic m);
        case (s)
            TLR:     return m ? TLR   : RTI;
            RTI:     return m ? SELDR : RTI;
            SELDR:   return m ? SELIR : CAPDR;
            CAPDR:   return m ? EX1DR : SHDR;
            SHDR:    return m ? EX1DR : SHDR;
            EX1DR:   return m ? UPDR  : PDR;
            PDR:     return m ? EX2DR : PDR;
            EX2DR:   return m ? UPDR  : SHDR;
            UPDR:    return m ? SELDR : RTI;
            SELIR:   return m ? TLR   : CAPIR;
            CAPIR:   return m ? EX1IR : SHIR;
            SHIR:    return m ? EX1IR : SHIR;
            EX1IR:   return m ? UPIR  : PIR;
            PIR:     return m ? EX2IR : PIR;
            EX2IR:   return m ? UPIR  : SHIR;
            UPIR:    return m ? SELDR : RTI;
            default: return TLR;
        endcase
    endfunction

    always @(posedge tck) begin
        tms_hist  <= {tms_hist[126:0], tms};
        tck_total <= tck_total + 1;
        case (tap_st)
            CAPDR: dr_bit <= 1'b0;
            SHDR: begin
                dr_bit    <= tdi;
                dr_shifts <= dr_shifts + 1;
            end
            CAPIR: ir_sh  <= ir_cap_pat;
            SHIR:  ir_sh  <= {tdi, ir_sh[3:1]};
            UPIR:  ir_reg <= ir_sh;
            TLR:   ir_reg <= 4'hF;
            default: ;
        endcase
        tap_st <= next_tap(tap_st, tms);
    end

    always @(negedge tck) begin
        tdo_r <= (tap_st == SHDR) ? dr_bit : ((tap_st == SHIR) ? ir_sh[0] : 1'b0);
    end

    // Scoreboard
    typedef struct {
        logic [31:0]  data;
        int           tcks;
        logic [127:0] tmsv;
        logic         chk_ir;
        logic [3:0]   ir;
        logic         err;
        int           base;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] build_tms(input logic skip, input int n);
        logic [127:0] v;
        v = '0;
        if (!skip) begin
            v = {v[123:0], 4'b1100};
            for (int i = 0; i < IR_W; i++) v = {v[126:0], (i == IR_W - 1)};
            v = {v[125:0], 2'b10};
        end
        if (n > 0) begin
            v = {v[124:0], 3'b100};
            for (int i = 0; i < n; i++) v = {v[126:0], (i == n - 1)};
            v = {v[125:0], 2'b10};
        end
        return v;
    endfunction

    // Monitor: compares every response against the oldest pending expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: rsp_valid with nothing pending, data %0h", rsp_data);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_data", rsp_data, e.data);
                    chk("tck_count", tck_total - e.base, e.tcks);
                    chk("tms_seq", tms_hist & ((128'd1 << e.tcks) - 128'd1), e.tmsv);
                    if (e.chk_ir) chk("ir_loaded", ir_reg, e.ir);
                    chk("ir_err", ir_err, e.err);
                end
            end
        end
    end

    task automatic send(input logic skip, input logic [3:0] ir, input logic [31:0] dr,
                        input logic [5:0] len, input logic [31:0] exp_data, input logic push);
        exp_t e;
        int   n;
        int   w;
        w = 0;
        while (!cmd_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: cmd_ready %0b required 1", cmd_ready);
        end
        n = (len > 6'd32) ? 32 : int'(len);
        cmd_skip_ir = skip;
        cmd_ir      = ir;
        cmd_dr      = dr;
        cmd_dr_len  = len;
        cmd_valid   = 1'b1;
        if (push) begin
            e.data   = exp_data;
            e.tcks   = (skip ? 0 : IR_W + 6) + ((n > 0) ? n + 5 : 0);
            e.tmsv   = build_tms(skip, n);
            e.chk_ir = !skip;
            e.ir     = ir;
`ifdef JTAG_IR_CHECK_EN
            e.err    = !skip && (ir_cap_pat[1:0] != 2'b01);
`else
            e.err    = 1'b0;
`endif
            e.base   = tck_total;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sbq.size() != 0 || !cmd_ready) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() != 0 || !cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: pending %0d required 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    task automatic init_check(input string tag);
        int base;
        int cyc;
        base = tck_total;
        cyc  = 0;
        @(negedge clk);
        rst = 1'b0;
        while (!cmd_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc < 12 * CD || cyc > 12 * CD + 2) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles required %0d..%0d", tag, cyc, 12 * CD, 12 * CD + 2);
        end
        chk({tag, "_tcks"}, tck_total - base, 6);
        chk({tag, "_tms"}, tms_hist[5:0], 6'b111110);
    endtask

    initial begin
        int base;
        int w;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_pins", {tck, tms, tdi, cmd_ready, rsp_valid, ir_err}, 6'b010000);
        chk("reset_rsp_data", rsp_data, 32'h0);
        init_check("init");

        send(1'b0, 4'b0011, 32'hDEADBEEF, 6'd32, 32'hBD5B7DDE, 1'b1);
        wait_idle();
        send(1'b0, 4'b1111, 32'h00000001, 6'd1, 32'h00000000, 1'b1);
        wait_idle();
        send(1'b1, 4'b0000, 32'h000000A5, 6'd8, 32'h0000004A, 1'b1);
        wait_idle();
        send(1'b1, 4'b0000, 32'h12345678, 6'd40, 32'h2468ACF0, 1'b1);
        wait_idle();
        send(1'b1, 4'b0000, 32'hFFFFFFFF, 6'd0, 32'h00000000, 1'b1);
        chk("zero_len_rsp_next_cycle", rsp_valid, 1'b1);
        wait_idle();

        ir_cap_pat = 4'b0000;
        send(1'b0, 4'b0001, 32'h00000003, 6'd2, 32'h00000002, 1'b1);
        wait_idle();
        ir_cap_pat = 4'b0001;
        send(1'b0, 4'b0010, 32'h00000000, 6'd0, 32'h00000000, 1'b1);
        chk("ir_err_cleared_on_accept", ir_err, 1'b0);
        wait_idle();

        // Abort a DR scan partway through with reset
        send(1'b1, 4'b0000, 32'hFFFF0000, 6'd32, 32'h0, 1'b0);
        base = dr_shifts;
        w    = 0;
        while ((dr_shifts - base) < 10 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_bit10", (dr_shifts - base) >= 10, 1'b1);
        #2 rst = 1'b1;
        #1 chk("abort_pins", {tck, tms, cmd_ready, rsp_valid}, 4'b0100);
        repeat (3) @(negedge clk);
        init_check("reinit");

        send(1'b0, 4'b0100, 32'h0F0F0F0F, 6'd16, 32'h00001E1E, 1'b1);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
